aq_fadd_align_shift_r_double: RTL and testbench

Right-shift alignment unit for the double-precision FADD datapath. It shifts the smaller-exponent 54-bit mantissa right by the exponent difference and produces guard, round and sticky bits. It is the counterpart to the post-subtract left normaliser.
- Two-stage pipeline with valid/ready handshake and flush.
- Sits between exponent compare and the mantissa adder.

---
 rtl/aq_fadd_pkg.sv | 25 ++
 rtl/aq_fadd_rshift_sticky.sv | 22 ++
 rtl/aq_fadd_align_shift_r_double.sv | 146 ++++++++++++++
 tb/tb_aq_fadd_align_shift_r_double.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/aq_fadd_pkg.sv
// Shared widths and stage-1 payload type for the FADD datapath.
// Contents:
//   AQ_FADD_MANT_W   mantissa width (54)
//   AQ_FADD_SHCNT_W  alignment shift count width (7)
//   AQ_FADD_GRS_W    guard/round/sticky width (3)
//   AQ_FADD_EXT_W    mantissa extended with G/R/S positions (57)
//   aq_fadd_s1_t     coarse-stage pipeline payload
package aq_fadd_pkg;

    localparam int unsigned AQ_FADD_MANT_W  = 54;
    localparam int unsigned AQ_FADD_SHCNT_W = 7;
    localparam int unsigned AQ_FADD_GRS_W   = 3;
    localparam int unsigned AQ_FADD_EXT_W   = 57;

    // Low count bits are applied by the fine stage, the rest by the coarse stage.
    localparam int unsigned AQ_FADD_FINE_W   = 3;
    localparam int unsigned AQ_FADD_COARSE_W = AQ_FADD_SHCNT_W - AQ_FADD_FINE_W;

    typedef struct packed {
        logic [AQ_FADD_EXT_W-1:0]  data;
        logic                      stk;
        logic [AQ_FADD_FINE_W-1:0] fine;
    } aq_fadd_s1_t;

endpackage

// File: rtl/aq_fadd_rshift_sticky.sv
// Combinational variable right shifter with sticky over the dropped bits.
// Ports:
//   in_data   [W-1:0]   value to shift
//   shift     [CW-1:0]  right-shift amount; amounts >= W yield zero
//   out_data  [W-1:0]   in_data >> shift
//   sticky    1         OR of every 1 bit shifted out below bit 0
module aq_fadd_rshift_sticky #(
    parameter int unsigned W  = 57,
    parameter int unsigned CW = 7
) (
    input  logic [W-1:0]  in_data,
    input  logic [CW-1:0] shift,
    output logic [W-1:0]  out_data,
    output logic          sticky
);

    assign out_data = in_data >> shift;

    // Shifting the result back recovers the kept bits; any difference was dropped.
    assign sticky = |(in_data ^ (out_data << shift));

endmodule

// File: rtl/aq_fadd_align_shift_r_double.sv
// Two-stage right-shift alignment of the smaller-exponent double mantissa,
// producing the aligned mantissa and guard/round/sticky bits.
// Stage 1 shifts by multiples of 8, stage 2 by the remaining 0..7.
// Optional feature macro: AQ_FADD_ALIGN_EXACT_EN adds out_exact.
// Ports:
//   forever_cpuclk        clock
//   cpurst                asynchronous active-high reset
//   flush                 synchronous kill of all in-flight entries
//   in_vld / in_rdy       input handshake (in_rdy is combinational)
//   in_data [53:0]        mantissa to align
//   in_shift_cnt [6:0]    right-shift amount
//   out_vld / out_rdy     output handshake
//   out_data [53:0]       aligned mantissa
//   out_grs [2:0]         {guard, round, sticky}
//   out_exact             (optional) no nonzero bit was shifted out
module aq_fadd_align_shift_r_double
    import aq_fadd_pkg::*;
(
    input  logic                       forever_cpuclk,
    input  logic                       cpurst,
    input  logic                       flush,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [AQ_FADD_MANT_W-1:0]  in_data,
    input  logic [AQ_FADD_SHCNT_W-1:0] in_shift_cnt,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [AQ_FADD_MANT_W-1:0]  out_data,
`ifdef AQ_FADD_ALIGN_EXACT_EN
    output logic                       out_exact,
`endif
    output logic [AQ_FADD_GRS_W-1:0]   out_grs
);

    logic                        s1_vld_q, s1_vld_d;
    aq_fadd_s1_t                 s1_q, s1_d;
    logic                        out_vld_q, out_vld_d;
    logic [AQ_FADD_MANT_W-1:0]   out_data_q, out_data_d;
    logic [AQ_FADD_GRS_W-1:0]    out_grs_q, out_grs_d;

    logic                        s2_adv_c;
    logic                        accept_c;
    logic                        s2_load_c;

    logic [AQ_FADD_EXT_W-1:0]    ext_c;
    logic [AQ_FADD_SHCNT_W-1:0]  coarse_cnt_c;
    logic [AQ_FADD_EXT_W-1:0]    coarse_data_c;
    logic                        coarse_stk_c;
    logic [AQ_FADD_EXT_W-1:0]    fine_data_c;
    logic                        fine_stk_c;

    // Coarse shift by cnt[6:3]*8; counts of 64+ shift everything out.
    assign ext_c        = {in_data, 3'b000};
    assign coarse_cnt_c = {in_shift_cnt[AQ_FADD_SHCNT_W-1:AQ_FADD_FINE_W], 3'b000};

    aq_fadd_rshift_sticky #(
        .W  (AQ_FADD_EXT_W),
        .CW (AQ_FADD_SHCNT_W)
    ) u_coarse (
        .in_data  (ext_c),
        .shift    (coarse_cnt_c),
        .out_data (coarse_data_c),
        .sticky   (coarse_stk_c)
    );

    aq_fadd_rshift_sticky #(
        .W  (AQ_FADD_EXT_W),
        .CW (AQ_FADD_FINE_W)
    ) u_fine (
        .in_data  (s1_q.data),
        .shift    (s1_q.fine),
        .out_data (fine_data_c),
        .sticky   (fine_stk_c)
    );

    // Pipeline control: flush wins over accept and advance.
    always_comb begin
        s2_adv_c   = !out_vld_q || out_rdy;
        in_rdy     = !s1_vld_q || s2_adv_c;
        accept_c   = in_vld && in_rdy && !flush;
        s2_load_c  = s2_adv_c && s1_vld_q && !flush;

        s1_vld_d   = s1_vld_q;
        s1_d       = s1_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_grs_d  = out_grs_q;

        if (accept_c) begin
            s1_d.data = coarse_data_c;
            s1_d.stk  = coarse_stk_c;
            s1_d.fine = in_shift_cnt[AQ_FADD_FINE_W-1:0];
        end

        if (flush)          s1_vld_d = 1'b0;
        else if (accept_c)  s1_vld_d = 1'b1;
        else if (s2_adv_c)  s1_vld_d = 1'b0;

        if (s2_load_c) begin
            out_data_d = fine_data_c[AQ_FADD_EXT_W-1:AQ_FADD_GRS_W];
            out_grs_d  = {fine_data_c[2], fine_data_c[1],
                          s1_q.stk | fine_stk_c | fine_data_c[0]};
        end

        if (flush)          out_vld_d = 1'b0;
        else if (s2_adv_c)  out_vld_d = s1_vld_q;
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            s1_vld_q   <= 1'b0;
            s1_q       <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_grs_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_q       <= s1_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_grs_q  <= out_grs_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_grs  = out_grs_q;

`ifdef AQ_FADD_ALIGN_EXACT_EN
    logic out_exact_q, out_exact_d;

    // Exact when nothing nonzero fell below the kept mantissa.
    always_comb begin
        out_exact_d = out_exact_q;
        if (s2_load_c) out_exact_d = (out_grs_d == 3'b000);
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) out_exact_q <= 1'b0;
        else        out_exact_q <= out_exact_d;
    end

    assign out_exact = out_exact_q;
`endif

endmodule

// File: tb/tb_aq_fadd_align_shift_r_double.sv
// Scoreboard bench for aq_fadd_align_shift_r_double.
// Inputs change on the falling edge; handshakes and outputs are sampled 1ns later.
module tb_aq_fadd_align_shift_r_double;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst;
    logic        flush;
    logic        in_vld;
    logic        in_rdy;
    logic [53:0] in_data;
    logic [6:0]  in_shift_cnt;
    logic        out_vld;
    logic        out_rdy;
    logic [53:0] out_data;
    logic [2:0]  out_grs;
`ifdef AQ_FADD_ALIGN_EXACT_EN
    logic        out_exact;
`endif

    int total = 0;
    int bad   = 0;
    logic [56:0] sb[$];

    always #5 forever_cpuclk = ~forever_cpuclk;

    aq_fadd_align_shift_r_double dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .flush          (flush),
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .in_data        (in_data),
        .in_shift_cnt   (in_shift_cnt),
        .out_vld        (out_vld),
        .out_rdy        (out_rdy),
        .out_data       (out_data),
`ifdef AQ_FADD_ALIGN_EXACT_EN
        .out_exact      (out_exact),
`endif
        .out_grs        (out_grs)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: bit-serial loss accumulation over the 57-bit extended mantissa.
    function automatic logic [56:0] model(input logic [53:0] d, input logic [6:0] c);
        logic [56:0] ext;
        logic [56:0] full;
        logic        lost;
        ext  = {d, 3'b000};
        lost = 1'b0;
        if (c >= 7'd57) return {54'd0, 2'b00, |d};
        full = ext >> c;
        for (int i = 0; i < 57; i++)
            if (i < int'(c) && ext[i]) lost = 1'b1;
        return {full[56:1], full[0] | lost};
    endfunction

    // One cycle: drive at negedge, sample handshakes, take the edge, return at next negedge.
    task automatic step(input logic v, input logic [53:0] d, input logic [6:0] c,
                        input logic r, input logic f, output logic acc);
        logic [56:0] exp;
        in_vld = v; in_data = d; in_shift_cnt = c; out_rdy = r; flush = f;
        #1;
        acc = v && in_rdy && !f;
        if (out_vld && out_rdy) begin
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("out_data", 64'(out_data), 64'(exp[56:3]));
                chk("out_grs", 64'(out_grs), 64'(exp[2:0]));
`ifdef AQ_FADD_ALIGN_EXACT_EN
                chk("out_exact", 64'(out_exact), 64'(exp[2:0] == 3'b000));
`endif
            end
        end
        if (f) sb.delete();
        else if (acc) sb.push_back(model(d, c));
        @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
    endtask

    task automatic idle(input int n, input logic r);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 54'd0, 7'd0, r, 1'b0, a);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0) && (n < 20)) begin
            idle(1, 1'b1);
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [53:0] rnd54();
        return {22'($urandom), $urandom};
    endfunction

    initial begin
        logic        a;
        logic [53:0] held;
        logic [2:0]  held_grs;
        logic [53:0] d;
        int          tries;

        cpurst = 1'b1; flush = 1'b0; in_vld = 1'b0; in_data = '0;
        in_shift_cnt = '0; out_rdy = 1'b0;
        @(negedge forever_cpuclk);
        @(negedge forever_cpuclk);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_grs", 64'(out_grs), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
`ifdef AQ_FADD_ALIGN_EXACT_EN
        chk("rst_out_exact", 64'(out_exact), 64'd0);
`endif
        cpurst = 1'b0;
        @(negedge forever_cpuclk);

        // Pass-through and two-cycle latency
        step(1'b1, 54'h20000000000000, 7'd0, 1'b1, 1'b0, a);
        chk("t1_accept", 64'(a), 64'd1);
        chk("t1_lat1", 64'(out_vld), 64'd0);
        idle(1, 1'b1);
        chk("t1_lat2", 64'(out_vld), 64'd1);
        chk("t1_data", 64'(out_data), 64'h20000000000000);
        chk("t1_grs", 64'(out_grs), 64'd0);
        drain("t1_drain");

        // Guard/round/sticky corners, back to back
        step(1'b1, 54'h3, 7'd1, 1'b1, 1'b0, a);
        step(1'b1, 54'h3, 7'd3, 1'b1, 1'b0, a);
        step(1'b1, 54'h1, 7'd60, 1'b1, 1'b0, a);
        step(1'b1, 54'h20000000000000, 7'd55, 1'b1, 1'b0, a);
        step(1'b1, 54'h3FFFFFFFFFFFFF, 7'd57, 1'b1, 1'b0, a);
        step(1'b1, 54'h3FFFFFFFFFFFFF, 7'd127, 1'b1, 1'b0, a);
        step(1'b1, 54'h0, 7'd100, 1'b1, 1'b0, a);
        step(1'b1, 54'h2AAAAAAAAAAAAA, 7'd63, 1'b1, 1'b0, a);
        step(1'b1, 54'h2AAAAAAAAAAAAA, 7'd64, 1'b1, 1'b0, a);
        step(1'b1, 54'h10000000000001, 7'd56, 1'b1, 1'b0, a);
        drain("t23_drain");
        chk("t3_model_hi", 64'(model(54'h20000000000000, 7'd55)), 64'h2);

        // Back-pressure: two accepts fill the pipe, then the output must freeze
        step(1'b1, rnd54(), 7'd8, 1'b0, 1'b0, a);
        chk("bp_acc1", 64'(a), 64'd1);
        step(1'b1, rnd54(), 7'd16, 1'b0, 1'b0, a);
        chk("bp_acc2", 64'(a), 64'd1);
        chk("bp_rdy_low", 64'(in_rdy), 64'd0);
        held = out_data; held_grs = out_grs;
        d = rnd54();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, d, 7'd24, 1'b0, 1'b0, a);
            chk("bp_no_acc", 64'(a), 64'd0);
            chk("bp_hold_data", 64'(out_data), 64'(held));
            chk("bp_hold_grs", 64'(out_grs), 64'(held_grs));
            chk("bp_hold_vld", 64'(out_vld), 64'd1);
        end
        tries = 0;
        a = 1'b0;
        while (!a && tries < 10) begin
            step(1'b1, d, 7'd24, 1'b1, 1'b0, a);
            tries++;
        end
        chk("bp_third_acc", 64'(a), 64'd1);
        drain("bp_drain");

        // Flush with both stages full and a concurrent input
        step(1'b1, rnd54(), 7'd9, 1'b0, 1'b0, a);
        step(1'b1, rnd54(), 7'd17, 1'b0, 1'b0, a);
        step(1'b1, rnd54(), 7'd5, 1'b0, 1'b1, a);
        chk("fl_out_vld", 64'(out_vld), 64'd0);
        chk("fl_s1_vld", 64'(dut.s1_vld_q), 64'd0);
        chk("fl_in_rdy", 64'(in_rdy), 64'd1);
        idle(4, 1'b1);
        chk("fl_quiet", 64'(out_vld), 64'd0);

        // Asynchronous reset mid-stream
        step(1'b1, rnd54(), 7'd2, 1'b0, 1'b0, a);
        step(1'b1, rnd54(), 7'd11, 1'b0, 1'b0, a);
        #2;
        cpurst = 1'b1;
        #1;
        chk("ar_out_vld", 64'(out_vld), 64'd0);
        chk("ar_out_data", 64'(out_data), 64'd0);
        chk("ar_out_grs", 64'(out_grs), 64'd0);
        sb.delete();
        @(negedge forever_cpuclk);
        cpurst = 1'b0;
        chk("ar_in_rdy", 64'(in_rdy), 64'd1);
        step(1'b1, 54'h155, 7'd4, 1'b1, 1'b0, a);
        chk("ar_acc", 64'(a), 64'd1);
        chk("ar_lat1", 64'(out_vld), 64'd0);
        idle(1, 1'b1);
        chk("ar_lat2", 64'(out_vld), 64'd1);
        drain("ar_drain");

        // Random traffic with stalls and occasional flush
        for (int i = 0; i < 300; i++) begin
            logic [6:0] c;
            c = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) c = 7'($urandom_range(52, 66));
            step(1'($urandom_range(0, 3) != 0), rnd54(), c,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0), a);
        end
        drain("rnd_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
